// File: rtl/accum_if.sv
// Handshake bundle for accum_seq: command/operand stream in, result stream out.
// master drives operands and takes results; slave is the accumulator.
interface accum_if #(
   parameter int dw = 8,
   parameter int cw = 4
);
   logic          start;
   logic [cw-1:0] count;
   logic          in_valid;
   logic          in_ready;
   logic [dw-1:0] in_data;
   logic          add_sub;
   logic          out_valid;
   logic          out_ready;
   logic [dw-1:0] out_sum;
   logic          out_ovf;
   logic          busy;

   modport master (
      output start, count, in_valid, in_data, add_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, busy
   );

   modport slave (
      input  start, count, in_valid, in_data, add_sub, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, busy
   );
endinterface

// File: rtl/accum_seq.sv
// Sequenced signed accumulator: start latches an operand count, each accepted
// operand is added or subtracted, and the result is held until taken downstream.
module accum_seq #(
   parameter int dw = 8,
   parameter int cw = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   accum_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [dw-1:0] acc_reg, acc_next;
   logic          ovf_reg, ovf_next;
   logic [cw-1:0] rem_reg, rem_next;

   logic [dw-1:0] sum_add;
   logic [dw-1:0] sum_sub;
   logic          ovf_add;
   logic          ovf_sub;
   logic          accept;

   assign sum_add = acc_reg + bus.in_data;
   assign sum_sub = acc_reg - bus.in_data;

   // Signed overflow judged from the sign bits of the old accumulator, the
   // operand and the truncated result.
   assign ovf_add = (acc_reg[dw-1] == bus.in_data[dw-1]) && (sum_add[dw-1] != acc_reg[dw-1]);
   assign ovf_sub = (acc_reg[dw-1] != bus.in_data[dw-1]) && (sum_sub[dw-1] != acc_reg[dw-1]);

   // Handshake outputs decode only registered state, so in_valid/out_ready
   // never reach in_ready/out_valid combinationally.
   assign bus.in_ready  = (state_reg == ACC);
   assign bus.out_valid = (state_reg == HOLD);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.out_sum   = acc_reg;
   assign bus.out_ovf   = ovf_reg;

   assign accept = bus.in_valid && (state_reg == ACC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         rem_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         ovf_reg   <= ovf_next;
         rem_reg   <= rem_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      ovf_next   = ovf_reg;
      rem_next   = rem_reg;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               acc_next   = '0;
               ovf_next   = 1'b0;
               rem_next   = bus.count;
               state_next = (bus.count != '0) ? ACC : HOLD;
            end
         end

         ACC: begin
            if (accept) begin
               if (bus.add_sub) begin
                  acc_next = sum_add;
                  ovf_next = ovf_reg | ovf_add;
               end else begin
                  acc_next = sum_sub;
                  ovf_next = ovf_reg | ovf_sub;
               end
               rem_next = rem_reg - cw'(1);
               if (rem_reg == cw'(1)) begin
                  state_next = HOLD;
               end
            end
         end

         HOLD: begin
            // start arriving with the handshake is dropped; IDLE sees it next cycle
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_accum_seq.sv
// Randomized scoreboard bench for accum_seq: the driver pushes expected results
// computed with plain signed arithmetic; a negedge monitor pops them on each output handshake.
module tb_accum_seq;

   localparam int DW = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;

   accum_if #(.dw(DW), .cw(CW)) bus ();

   accum_seq #(.dw(DW), .cw(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int hs_count = 0;

   logic [DW:0] exp_q[$];
   logic [DW-1:0] d_arr[16];
   bit            a_arr[16];

   logic rst_q = 1'b1;
   always @(posedge clk) rst_q <= rst_n;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: reset-state checks, HOLD stability, and scoreboard pops on handshakes.
   logic [DW-1:0] prev_sum;
   logic          prev_ovf;
   bit            have_prev = 0;

   always @(negedge clk) begin
      if (!rst_q) begin
         check("rst_in_ready", bus.in_ready, 0);
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_out_sum", bus.out_sum, 0);
         check("rst_out_ovf", bus.out_ovf, 0);
         check("rst_busy", bus.busy, 0);
         have_prev = 0;
      end else if (bus.out_valid) begin
         check("hold_in_ready", bus.in_ready, 0);
         if (have_prev) begin
            check("hold_sum_stable", bus.out_sum, prev_sum);
            check("hold_ovf_stable", bus.out_ovf, prev_ovf);
         end
         prev_sum  = bus.out_sum;
         prev_ovf  = bus.out_ovf;
         have_prev = 1;
         if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=0x%0h required=none at %0t", bus.out_sum, $time);
            end else begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               check("out_sum", bus.out_sum, e[DW-1:0]);
               check("out_ovf", bus.out_ovf, e[DW]);
            end
            hs_count++;
            have_prev = 0;
         end
      end else begin
         have_prev = 0;
      end
   end

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.count     = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.add_sub   = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   // One full sequence: start, operands from d_arr/a_arr with random bubbles,
   // a stall of `stall` cycles in HOLD (optionally poking start/in_valid), then handshake.
   task automatic run_seq(input int n, input int gap_pct, input int stall, input bit poke);
      int k;
      int budget;
      int full;
      int hs0;
      logic [DW-1:0] s;
      bit ov;
      logic rdy;

      bus.start = 1'b1;
      bus.count = CW'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      s = '0;
      ov = 0;
      k = 0;
      budget = 0;
      while (k < n && budget < 200) begin
         if ($urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = DW'($urandom);
            bus.add_sub  = 1'($urandom);
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = d_arr[k];
            bus.add_sub  = a_arr[k];
         end
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (bus.in_valid && rdy) begin
            full = a_arr[k] ? (int'($signed(s)) + int'($signed(d_arr[k])))
                            : (int'($signed(s)) - int'($signed(d_arr[k])));
            if (full > 127 || full < -128) ov = 1;
            s = DW'(full);
            k++;
         end
         #1;
         budget++;
      end
      bus.in_valid = 1'b0;
      if (k < n) begin
         checks++;
         errors++;
         $display("FAIL operand_accept_timeout actual=%0d required=%0d", k, n);
         return;
      end
      exp_q.push_back({ov, s});

      // Result must be presented the cycle after the final accept (or after start for n==0).
      @(negedge clk);
      check("out_valid_latency", bus.out_valid, 1);
      check("in_ready_in_hold", bus.in_ready, 0);
      @(posedge clk); #1;

      for (int i = 0; i < stall; i++) begin
         if (poke) begin
            bus.start    = 1'b1;
            bus.count    = CW'($urandom_range(1, 15));
            bus.in_valid = 1'b1;
            bus.in_data  = DW'($urandom);
         end
         @(negedge clk);
         @(posedge clk); #1;
      end

      bus.out_ready = 1'b1;
      hs0 = hs_count;
      budget = 0;
      while (hs_count == hs0 && budget < 20) begin
         @(negedge clk);
         @(posedge clk); #1;
         budget++;
      end
      if (hs_count == hs0) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout actual=%0d required=%0d", hs_count, hs0 + 1);
      end
      idle_inputs();
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", bus.busy, 0);
      @(posedge clk); #1;

      // +10 +20 -5, back-to-back
      d_arr[0] = 8'd10; a_arr[0] = 1;
      d_arr[1] = 8'd20; a_arr[1] = 1;
      d_arr[2] = 8'd5;  a_arr[2] = 0;
      run_seq(3, 0, 0, 0);

      // 100+100 overflows; next sequence clears the sticky flag
      d_arr[0] = 8'd100; a_arr[0] = 1;
      d_arr[1] = 8'd100; a_arr[1] = 1;
      run_seq(2, 0, 1, 0);
      d_arr[0] = 8'd1; a_arr[0] = 0;
      run_seq(1, 0, 0, 0);

      // empty sequence
      run_seq(0, 0, 0, 0);

      // bubbles between operands carry junk data
      d_arr[0] = 8'd1; a_arr[0] = 1;
      d_arr[1] = 8'd2; a_arr[1] = 1;
      d_arr[2] = 8'd3; a_arr[2] = 1;
      run_seq(3, 50, 0, 0);

      // long HOLD stall with start/in_valid poked, including the handshake cycle
      d_arr[0] = 8'h7f; a_arr[0] = 1;
      d_arr[1] = 8'h80; a_arr[1] = 0;
      run_seq(2, 0, 5, 1);

      // reset after one accepted operand discards the partial sequence
      bus.start = 1'b1;
      bus.count = CW'(3);
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd9;
      bus.add_sub  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("after_rst_busy", bus.busy, 0);
      check("after_rst_sum", bus.out_sum, 0);
      check("after_rst_out_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      d_arr[0] = 8'd5; a_arr[0] = 1;
      run_seq(1, 0, 0, 0);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) begin
            d_arr[i] = DW'($urandom);
            a_arr[i] = 1'($urandom);
         end
         run_seq($urandom_range(0, 15), 30, $urandom_range(0, 4), 1'($urandom));
      end

      repeat (2) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
